fft_r22sdf_bf: RTL and testbench
================================

FFT_R22SDF_BF -- requirements
Module: fft_r22sdf_bf

Interface
REQ-001 DATA_WIDTH, 25, signed width of each real/imaginary component at input and output.
REQ-002 SHIFT_REG_LEN, 512, feedback delay depth L in samples; power of two, >= 1.
REQ-003 BF_TYPE, 0, 0 = BF-I (trivial butterfly), 1 = BF-II (butterfly with -j rotation).
REQ-004 clk_i  in  1  sole clock; all state updates on rising edge.
REQ-005 rst_n  in  1  reset, synchronous and active-low.
REQ-006 valid_i  in  1  input sample qualifier; state advances only when high.
REQ-007 x_re_i, x_im_i  in  DATA_WIDTH each  signed input sample.
REQ-008 valid_o  out  1  registered output qualifier.
REQ-009 z_re_o, z_im_o  out  DATA_WIDTH each  signed registered output sample.
REQ-010 sync_o  out  1  registered pulse with the first valid output of each frame (count phase 0 emerging).

Function
REQ-011 Internal sample counter cnt SHALL be log2(L)+1 bits for BF-I and log2(L)+2 bits for BF-II; increments by 1 per accepted sample (valid_i=1), wraps modulo 2L (BF-I) or 4L (BF-II).
REQ-012 Control bits: s = cnt[log2 L]; t = cnt[log2 L + 1] (BF-II only).
REQ-013 BF-II: when t=1 and s=1, input SHALL be rotated by -j before the butterfly (re' = x_im_i, im' = -x_re_i); otherwise re' = x_re_i, im' = x_im_i. BF-I: no rotation.
REQ-014 Delay line: two L-deep lines (re/im), clock-enabled by valid_i; when valid_i=0 contents, cnt and outputs hold.
REQ-015 s=0: line input = x', output candidate = line tail.
REQ-016 s=1: output candidate = x' + tail; line input = tail - x'.
REQ-017 Arithmetic is DATA_WIDTH wide; overflow behaviour per REQ-027/028.
REQ-018 z_re_o/z_im_o SHALL register the output candidate on each accepted sample; latency one cycle from accepting valid_i.
REQ-019 primed flag SHALL set on the first accepted sample with s=1 and stay set until reset.
REQ-020 valid_o SHALL equal (valid_i AND (primed OR s=1)), registered; valid_o low for the first L accepted samples after reset.
REQ-021 sync_o SHALL assert with valid_o when the accepted sample had cnt = L (first s=1 sample of a frame, BF-I) or cnt = L with t=0 (BF-II); low otherwise.
REQ-022 L=1: delay line is a single register; s toggles every accepted sample.
REQ-023 Counter wrap SHALL be seamless: back-to-back frames produce continuous valid_o with no bubble.

Reset
REQ-024 rst_n=0 at a clock edge SHALL clear cnt, primed, both delay lines, z_re_o, z_im_o, valid_o and sync_o to 0.
REQ-025 Reset SHALL take priority over valid_i at the same edge.
REQ-026 Reset mid-frame discards all stored samples; following behaviour is identical to power-up.

Configuration
REQ-027 With FFT_R22SDF_BF_SATURATE_EN defined, every sum/difference in REQ-013/016 SHALL saturate to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1]; -j rotation of the most negative value yields the maximum positive.
REQ-028 Without FFT_R22SDF_BF_SATURATE_EN, results SHALL wrap (two's-complement truncation), with no added logic.

Verification
REQ-029 BF-I, L=4, DATA_WIDTH=8, re inputs 1..8 continuous, im=0 -> valid_o low for 4 cycles, then z_re 6,8,10,12 (sync_o on first); next inputs 9..12 -> z_re -4,-4,-4,-4.
REQ-030 Same stimulus with valid_i low every other cycle -> identical output sequence, valid_o pulsed only after accepted samples, values hold during gaps.
REQ-031 BF-I, DATA_WIDTH=8, stored 100 then input 100 at s=1 -> z_re 127 with FFT_R22SDF_BF_SATURATE_EN, -56 without.
REQ-032 BF-II, L=2, input re=1..8, im=0 -> samples 7,8 (t=1,s=1) rotated to (0,-7),(0,-8) before butterfly; outputs checked against a golden model of REQ-013..016.
REQ-033 rst_n low for 1 cycle after 3 accepted samples of a frame -> all outputs 0 next cycle; rerunning REQ-029 stimulus gives identical results.
REQ-034 Continuous input over 3 frames (L=4) -> valid_o never drops after priming; sync_o once every 8 accepted samples.

Source files
------------

// File: rtl/fft_r22sdf_bf.sv
// Radix-2^2 SDF butterfly stage (BF-I or BF-II) with an L-deep feedback delay line.
// Define FFT_R22SDF_BF_SATURATE_EN to saturate sums/differences instead of wrapping.
module fft_r22sdf_bf #(
  parameter int unsigned DATA_WIDTH    = 25,
  parameter int unsigned SHIFT_REG_LEN = 512,
  parameter int unsigned BF_TYPE       = 0
) (
  input  logic                         clk_i,
  input  logic                         rst_n,
  input  logic                         valid_i,
  input  logic signed [DATA_WIDTH-1:0] x_re_i,
  input  logic signed [DATA_WIDTH-1:0] x_im_i,
  output logic                         valid_o,
  output logic signed [DATA_WIDTH-1:0] z_re_o,
  output logic signed [DATA_WIDTH-1:0] z_im_o,
  output logic                         sync_o
);

  localparam int unsigned LogL = $clog2(SHIFT_REG_LEN);
  localparam int unsigned CntW = LogL + ((BF_TYPE == 1) ? 2 : 1);

  typedef logic signed [DATA_WIDTH-1:0] smp_t;

`ifdef FFT_R22SDF_BF_SATURATE_EN
  localparam smp_t MaxVal = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam smp_t MinVal = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  // One extra bit exposes overflow: top two bits differ exactly when the result left range.
  function automatic smp_t clamp_f(input logic signed [DATA_WIDTH:0] full);
    if (full[DATA_WIDTH] != full[DATA_WIDTH-1]) begin
      return full[DATA_WIDTH] ? MinVal : MaxVal;
    end
    return full[DATA_WIDTH-1:0];
  endfunction

  function automatic smp_t add_f(input smp_t a, input smp_t b);
    return clamp_f({a[DATA_WIDTH-1], a} + {b[DATA_WIDTH-1], b});
  endfunction

  function automatic smp_t sub_f(input smp_t a, input smp_t b);
    return clamp_f({a[DATA_WIDTH-1], a} - {b[DATA_WIDTH-1], b});
  endfunction
`else
  function automatic smp_t add_f(input smp_t a, input smp_t b);
    return a + b;
  endfunction

  function automatic smp_t sub_f(input smp_t a, input smp_t b);
    return a - b;
  endfunction
`endif

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            primed_q, primed_d;
  logic            valid_q, valid_d;
  logic            sync_q, sync_d;
  smp_t            z_re_q, z_re_d, z_im_q, z_im_d;
  smp_t            dl_re_q [SHIFT_REG_LEN];
  smp_t            dl_im_q [SHIFT_REG_LEN];
  smp_t            line_re_d, line_im_d;
  smp_t            xr, xi, tail_re, tail_im;
  logic            s, t;

  always_comb begin
    s       = cnt_q[LogL];
    t       = (BF_TYPE == 1) ? cnt_q[CntW-1] : 1'b0;
    tail_re = dl_re_q[SHIFT_REG_LEN-1];
    tail_im = dl_im_q[SHIFT_REG_LEN-1];
    // -j rotation for the last quarter of a BF-II frame.
    if (t && s) begin
      xr = x_im_i;
      xi = sub_f('0, x_re_i);
    end else begin
      xr = x_re_i;
      xi = x_im_i;
    end
    if (s) begin
      z_re_d    = add_f(xr, tail_re);
      z_im_d    = add_f(xi, tail_im);
      line_re_d = sub_f(tail_re, xr);
      line_im_d = sub_f(tail_im, xi);
    end else begin
      z_re_d    = tail_re;
      z_im_d    = tail_im;
      line_re_d = xr;
      line_im_d = xi;
    end
    cnt_d    = cnt_q + CntW'(1);
    primed_d = primed_q | s;
    valid_d  = valid_i & (primed_q | s);
    sync_d   = valid_i & (cnt_q == CntW'(SHIFT_REG_LEN));
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      primed_q <= 1'b0;
      valid_q  <= 1'b0;
      sync_q   <= 1'b0;
      z_re_q   <= '0;
      z_im_q   <= '0;
      for (int i = 0; i < SHIFT_REG_LEN; i++) begin
        dl_re_q[i] <= '0;
        dl_im_q[i] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      sync_q  <= sync_d;
      if (valid_i) begin
        cnt_q      <= cnt_d;
        primed_q   <= primed_d;
        z_re_q     <= z_re_d;
        z_im_q     <= z_im_d;
        dl_re_q[0] <= line_re_d;
        dl_im_q[0] <= line_im_d;
        for (int i = 1; i < SHIFT_REG_LEN; i++) begin
          dl_re_q[i] <= dl_re_q[i-1];
          dl_im_q[i] <= dl_im_q[i-1];
        end
      end
    end
  end

  assign valid_o = valid_q;
  assign sync_o  = sync_q;
  assign z_re_o  = z_re_q;
  assign z_im_o  = z_im_q;

endmodule

// File: tb/tb_fft_r22sdf_bf.sv
// Bench for fft_r22sdf_bf: a BF-I (L=4) and a BF-II (L=2) instance, both 8 bits wide, share stimulus.
module tb_fft_r22sdf_bf;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              valid_i = 1'b0;
  logic signed [7:0] x_re_i = '0;
  logic signed [7:0] x_im_i = '0;
  logic              v1, sy1, v2, sy2;
  logic signed [7:0] zr1, zi1, zr2, zi2;

  int checks = 0;
  int failures = 0;

  int hre[$];
  int him[$];
  int ezr[2], ezi[2];
  bit ev[2], esy[2];

  always #5 clk = ~clk;

  fft_r22sdf_bf #(.DATA_WIDTH(8), .SHIFT_REG_LEN(4), .BF_TYPE(0)) u_bf1 (
    .clk_i(clk), .rst_n(rst_n), .valid_i(valid_i), .x_re_i(x_re_i), .x_im_i(x_im_i),
    .valid_o(v1), .z_re_o(zr1), .z_im_o(zi1), .sync_o(sy1)
  );

  fft_r22sdf_bf #(.DATA_WIDTH(8), .SHIFT_REG_LEN(2), .BF_TYPE(1)) u_bf2 (
    .clk_i(clk), .rst_n(rst_n), .valid_i(valid_i), .x_re_i(x_re_i), .x_im_i(x_im_i),
    .valid_o(v2), .z_re_o(zr2), .z_im_o(zi2), .sync_o(sy2)
  );

  function automatic int sat(input int v);
`ifdef FFT_R22SDF_BF_SATURATE_EN
    if (v > 127) return 127;
    if (v < -128) return -128;
    return v;
`else
    logic signed [7:0] b;
    b = v[7:0];
    return int'(b);
`endif
  endfunction

  // Butterfly input after optional -j rotation (last quarter of a 4L BF-II frame).
  function automatic int xp(input int l, input bit bf2, input int idx, input bit im);
    bit rot;
    rot = bf2 && ((idx % (4 * l)) >= 3 * l);
    if (!rot) return im ? him[idx] : hre[idx];
    return im ? sat(-hre[idx]) : him[idx];
  endfunction

  // Second half of each 2L pair period emits a+b; first half of the next emits a-b.
  function automatic int zexp(input int l, input bit bf2, input int m, input bit im);
    if ((m % (2 * l)) >= l) return sat(xp(l, bf2, m - l, im) + xp(l, bf2, m, im));
    if (m >= 2 * l) return sat(xp(l, bf2, m - 2 * l, im) - xp(l, bf2, m - l, im));
    return 0;
  endfunction

  task automatic chk(input string tag, input logic signed [31:0] obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic compare();
    chk("bf1_valid", {31'd0, v1}, int'(ev[0]));
    chk("bf1_sync", {31'd0, sy1}, int'(esy[0]));
    chk("bf1_zre", zr1, ezr[0]);
    chk("bf1_zim", zi1, ezi[0]);
    chk("bf2_valid", {31'd0, v2}, int'(ev[1]));
    chk("bf2_sync", {31'd0, sy2}, int'(esy[1]));
    chk("bf2_zre", zr2, ezr[1]);
    chk("bf2_zim", zi2, ezi[1]);
  endtask

  task automatic model_clear();
    hre.delete();
    him.delete();
    for (int k = 0; k < 2; k++) begin
      ezr[k] = 0; ezi[k] = 0; ev[k] = 1'b0; esy[k] = 1'b0;
    end
  endtask

  task automatic step(input bit v, input int re, input int im);
    int m, l;
    bit bf2;
    valid_i = v;
    x_re_i  = re[7:0];
    x_im_i  = im[7:0];
    @(posedge clk);
    #1;
    if (v) begin
      hre.push_back(re);
      him.push_back(im);
      m = hre.size() - 1;
      for (int k = 0; k < 2; k++) begin
        bf2    = (k == 1);
        l      = bf2 ? 2 : 4;
        ezr[k] = zexp(l, bf2, m, 1'b0);
        ezi[k] = zexp(l, bf2, m, 1'b1);
        ev[k]  = (m >= l);
        esy[k] = ((m % (bf2 ? 4 * l : 2 * l)) == l);
      end
    end else begin
      ev[0] = 1'b0; ev[1] = 1'b0; esy[0] = 1'b0; esy[1] = 1'b0;
    end
    compare();
  endtask

  // Reset asserted together with valid_i to show reset wins.
  task automatic do_reset();
    rst_n   = 1'b0;
    valid_i = 1'b1;
    x_re_i  = 8'sd55;
    x_im_i  = -8'sd33;
    @(posedge clk);
    #1;
    model_clear();
    compare();
    rst_n   = 1'b1;
    valid_i = 1'b0;
  endtask

  // Known-answer run: BF-I re 1..12, optionally with an idle cycle after each sample.
  task automatic run_ka(input bit gaps);
    int ka [8];
    ka = '{6, 8, 10, 12, -4, -4, -4, -4};
    for (int i = 1; i <= 12; i++) begin
      step(1'b1, i, 0);
      if (i >= 5) chk("ka_zre", zr1, ka[i-5]);
      chk("ka_sync", {31'd0, sy1}, (i == 5) ? 1 : 0);
      chk("ka_valid", {31'd0, v1}, (i >= 5) ? 1 : 0);
      if (gaps) begin
        step(1'b0, 99, -99);
        chk("ka_gap_valid", {31'd0, v1}, 0);
        if (i >= 5) chk("ka_gap_hold", zr1, ka[i-5]);
      end
    end
  endtask

  initial begin
    int vs, sync_cnt;
    model_clear();
    do_reset();
    do_reset();

    run_ka(1'b0);

    // Continue the stream for three full BF-I frames; valid must not drop once primed.
    sync_cnt = 0;
    for (int i = 13; i <= 28; i++) begin
      step(1'b1, i, -i);
      chk("cont_valid", {31'd0, v1}, 1);
      if (sy1) sync_cnt++;
    end
    chk("cont_sync_count", sync_cnt, 2);

    // Mid-frame reset, then the known-answer run must repeat exactly.
    do_reset();
    for (int i = 1; i <= 3; i++) step(1'b1, 40 + i, i);
    do_reset();
    run_ka(1'b0);

    do_reset();
    run_ka(1'b1);

    // Overflow at the butterfly: 100 stored, 100 arriving at s=1.
    do_reset();
    for (int i = 0; i < 4; i++) step(1'b1, 100, -100);
    step(1'b1, 100, -100);
`ifdef FFT_R22SDF_BF_SATURATE_EN
    chk("ovf_re", zr1, 127);
    chk("ovf_im", zi1, -128);
`else
    chk("ovf_re", zr1, -56);
    chk("ovf_im", zi1, 56);
`endif

    // Random traffic including extreme values and idle cycles.
    do_reset();
    for (int i = 0; i < 300; i++) begin
      vs = ($urandom_range(0, 3) != 0) ? 1 : 0;
      if ($urandom_range(0, 9) == 0) step(vs[0], -128, (i % 2 == 0) ? 127 : -128);
      else step(vs[0], int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 255)) - 128);
      if (i == 150) do_reset();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
